// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one in-flight slot, 2-deep {inst,pc} buffer.
// FETCH_PERF_CNT_EN adds fetched/squashed saturating counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        dec_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetched_cnt_o,
  output logic [31:0] squashed_cnt_o
`endif
);

  logic [31:0] pc_q;
  logic        infl_q;
  logic [31:0] infl_pc_q;

  logic [31:0] inst_mem_q [2];
  logic [31:0] pc_mem_q   [2];
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  cnt_q;

  logic        pop;
  logic        push;
  logic        issue;
  logic [1:0]  occ;
  logic [31:0] tgt;
  logic        unused_tgt;

  assign unused_tgt = ^branch_target_i[1:0];
  assign tgt        = {branch_target_i[31:2], 2'b00};

  assign inst_valid_o = (cnt_q != 2'd0);
  assign inst_o       = inst_mem_q[rd_q];
  assign inst_pc_o    = pc_mem_q[rd_q];
  assign pc_o         = pc_q;

  // Slots committed for next cycle: held entries left after pop plus
  // the in-flight return. Also the number squashed on a redirect.
  always_comb begin
    pop   = inst_valid_o & dec_ready_i;
    occ   = cnt_q - {1'b0, pop} + {1'b0, infl_q};
    issue = (occ < 2'(DEPTH)) & ~branch_i;
    push  = infl_q & ~branch_i;
  end

  // PC and in-flight tracking; redirect wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= 32'd0;
    end else if (branch_i) begin
      pc_q      <= tgt;
      infl_q    <= 1'b0;
    end else if (issue) begin
      pc_q      <= pc_q + 32'd4;
      infl_q    <= 1'b1;
      infl_pc_q <= pc_q;
    end else begin
      infl_q    <= 1'b0;
    end
  end

  // Two-entry FIFO; a redirect flushes it and rewinds both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        inst_mem_q[i] <= 32'd0;
        pc_mem_q[i]   <= 32'd0;
      end
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (branch_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        inst_mem_q[wr_q] <= inst_i;
        pc_mem_q[wr_q]   <= infl_pc_q;
        wr_q             <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] fet_sum;
  logic [32:0] sq_sum;

  always_comb begin
    fet_sum = {1'b0, fetched_cnt_o} + 33'd1;
    sq_sum  = {1'b0, squashed_cnt_o} + {31'd0, occ};
  end

  // Saturating counts of delivered and discarded instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_cnt_o  <= 32'd0;
      squashed_cnt_o <= 32'd0;
    end else begin
      if (pop) begin
        fetched_cnt_o <= fet_sum[32] ? 32'hFFFF_FFFF
                                     : fet_sum[31:0];
      end
      if (branch_i) begin
        squashed_cnt_o <= sq_sum[32] ? 32'hFFFF_FFFF
                                     : sq_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, directed
// scenarios then randomized redirects, stalls and resets.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        dec_ready_i;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt_o;
  logic [31:0] squashed_cnt_o;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_o            (pc_o),
    .inst_i          (inst_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .dec_ready_i     (dec_ready_i)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt_o   (fetched_cnt_o),
    .squashed_cnt_o  (squashed_cnt_o)
`endif
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3} + 32'h1357;
  endfunction

  // Synchronous code memory: returns the word at last edge's address.
  always @(posedge clk) inst_i <= mem_f(pc_o);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          m_infl;
  logic [31:0] m_ipc;
  logic [31:0] m_pc;
  longint      m_fet;
  longint      m_sq;

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_infl = 1'b0;
    m_ipc  = 32'd0;
    m_pc   = RST_PC;
    m_fet  = 0;
    m_sq   = 0;
  endtask

  task automatic check_out();
    chk("pc_o", pc_o, m_pc);
    chk("valid", 32'(inst_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("inst_o", inst_o, q[0].inst);
      chk("inst_pc_o", inst_pc_o, q[0].pc);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("fetched_cnt", fetched_cnt_o, sat32(m_fet));
    chk("squashed_cnt", squashed_cnt_o, sat32(m_sq));
`endif
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_edge(input bit br,
                            input logic [31:0] tgt,
                            input bit rdy);
    bit pop;
    int occ;
    pop = (q.size() != 0) && rdy;
    occ = q.size() - (pop ? 1 : 0) + (m_infl ? 1 : 0);
    if (pop) m_fet++;
    if (br) begin
      m_sq  += occ;
      q.delete();
      m_infl = 1'b0;
      m_pc   = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back('{mem_f(m_ipc), m_ipc});
      if (occ < 2) begin
        m_infl = 1'b1;
        m_ipc  = m_pc;
        m_pc   = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the next one.
  task automatic step(input bit br,
                      input logic [31:0] tgt,
                      input bit rdy);
    check_out();
    branch_i        = br;
    branch_target_i = tgt;
    dec_ready_i     = rdy;
    #1;
    chk("no_overflow",
        32'(dut.infl_q & ~br & (dut.cnt_q == 2'd2) &
            ~(inst_valid_o & rdy)), 32'd0);
    model_edge(br, tgt, rdy);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    chk({tag, "_pc"}, pc_o, RST_PC);
    chk({tag, "_inst"}, inst_o, 32'd0);
    chk({tag, "_ipc"}, inst_pc_o, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_fcnt"}, fetched_cnt_o, 32'd0);
    chk({tag, "_scnt"}, squashed_cnt_o, 32'd0);
`endif
  endtask

  // Asynchronous reset between edges; outputs must drop at once.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    branch_i        = 1'b0;
    branch_target_i = 32'd0;
    dec_ready_i     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;

    // Streaming from reset.
    repeat (6) step(1'b0, 32'd0, 1'b1);

    // Stall right after the first valid, then drain.
    mid_reset();
    repeat (2) step(1'b0, 32'd0, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b0);
    repeat (8) step(1'b0, 32'd0, 1'b1);

    // Redirect while the buffer is full.
    repeat (3) step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h0000_003C, 1'b0);
    repeat (5) step(1'b0, 32'd0, 1'b1);

    // Unaligned target and redirect alongside a transfer.
    step(1'b1, 32'h0000_0043, 1'b1);
    chk("tgt_align", pc_o, 32'h0000_0040);
    mid_reset();
    repeat (4) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1);

    // Back-to-back redirects.
    step(1'b1, 32'h0000_0080, 1'b1);
    step(1'b1, 32'h0000_0090, 1'b0);
    step(1'b1, 32'h0000_00A0, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b1);

    // Address wrap.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b1);
    chk("wrap", pc_o, 32'h0000_0000);
    repeat (4) step(1'b0, 32'd0, 1'b1);

    // Reset with one entry held.
    mid_reset();
    repeat (4) step(1'b0, 32'd0, 1'b1);
    mid_reset();
    repeat (3) step(1'b0, 32'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          br;
      bit          rdy;
      logic [31:0] tgt;
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        br  = ($urandom_range(0, 7) == 0);
        rdy = ($urandom_range(0, 9) < 7);
        tgt = ($urandom_range(0, 3) == 0)
              ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
              : 32'($urandom);
        step(br, tgt, rdy);
      end
    end
    check_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
